// File: rtl/lc3_writeback_sequencer.sv
// ---------------------------------------------------------------------------
// lc3_writeback_sequencer
//
// Control FSM between the LC3 execute stage and the writeback stage. Takes
// one decoded instruction at a time, runs the memory accesses it needs, and
// drives the register-file writeback controls.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   ex_valid/ex_ready   handshake with execute (ready only while IDLE)
//   ex_opcode, ex_dr    IR[15:12] and destination register of the instruction
//   mem_req/mem_rw      memory request (held until mem_ack), 0=read 1=write
//   mem_addr_sel        0 = computed pcout address, 1 = indirect (memout)
//   mem_ack             memory finished the current access this cycle
//   W_Control, dr       writeback mux select / register address (held
//                       from accept until the next accept)
//   enable_writeback    1-cycle register-file write strobe
//   retire, mem_error,
//   illegal_op          1-cycle status pulses
// ---------------------------------------------------------------------------
module lc3_writeback_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ex_valid,
    output logic       ex_ready,
    input  logic [3:0] ex_opcode,
    input  logic [2:0] ex_dr,
    output logic       mem_req,
    output logic       mem_rw,
    output logic       mem_addr_sel,
    input  logic       mem_ack,
    output logic [1:0] W_Control,
    output logic       enable_writeback,
    output logic [2:0] dr,
    output logic       retire,
    output logic       mem_error,
    output logic       illegal_op
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WB     = 3'd1;
    localparam logic [2:0] S_RD     = 3'd2;
    localparam logic [2:0] S_RD_IND = 3'd3;
    localparam logic [2:0] S_WR     = 3'd4;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [2:0]       dr_q, dr_d;
    logic [1:0]       wctl_q, wctl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire_p_q, retire_p_d;   // retire outside WB (CTRL, WR done)
    logic             err_q, err_d;
    logic             ill_q, ill_d;

    logic in_mem;
    assign in_mem = (state_q == S_RD) || (state_q == S_RD_IND) || (state_q == S_WR);

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        dr_d       = dr_q;
        wctl_d     = wctl_q;
        cnt_d      = cnt_q;
        retire_p_d = 1'b0;
        err_d      = 1'b0;
        ill_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    opcode_d = ex_opcode;
                    dr_d     = ex_dr;
                    wctl_d   = 2'd0;
                    cnt_d    = '0;
                    case (ex_opcode)
                        OP_ADD, OP_AND, OP_NOT: state_d = S_WB;
                        OP_LEA: begin
                            state_d = S_WB;
                            wctl_d  = 2'd1;
                        end
                        OP_LD, OP_LDR, OP_LDI: begin
                            state_d = S_RD;
                            wctl_d  = 2'd2;
                        end
                        OP_STI:        state_d = S_RD;
                        OP_ST, OP_STR: state_d = S_WR;
                        // Control flow has nothing to write back; stay in IDLE
                        OP_BR, OP_JMP: retire_p_d = 1'b1;
                        default: begin
                            retire_p_d = 1'b1;
                            ill_d      = 1'b1;
                        end
                    endcase
                end
            end
            S_WB: state_d = S_IDLE;
            S_RD, S_RD_IND, S_WR: begin
                // An ack on the limit cycle still completes the access.
                if (mem_ack) begin
                    cnt_d = '0;
                    case (state_q)
                        S_RD: begin
                            if (opcode_q == OP_LDI)      state_d = S_RD_IND;
                            else if (opcode_q == OP_STI) state_d = S_WR;
                            else                         state_d = S_WB;
                        end
                        S_RD_IND: state_d = S_WB;
                        default: begin
                            state_d    = S_IDLE;
                            retire_p_d = 1'b1;
                        end
                    endcase
                end else if (cnt_q == CNT_LIMIT) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            opcode_q   <= '0;
            dr_q       <= '0;
            wctl_q     <= '0;
            cnt_q      <= '0;
            retire_p_q <= 1'b0;
            err_q      <= 1'b0;
            ill_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            dr_q       <= dr_d;
            wctl_q     <= wctl_d;
            cnt_q      <= cnt_d;
            retire_p_q <= retire_p_d;
            err_q      <= err_d;
            ill_q      <= ill_d;
        end
    end

    assign ex_ready         = (state_q == S_IDLE);
    assign mem_req          = in_mem;
    assign mem_rw           = (state_q == S_WR);
    assign mem_addr_sel     = (state_q == S_RD_IND) || ((state_q == S_WR) && (opcode_q == OP_STI));
    assign W_Control        = wctl_q;
    assign dr               = dr_q;
    assign enable_writeback = (state_q == S_WB);
    assign retire           = (state_q == S_WB) || retire_p_q;
    assign mem_error        = err_q;
    assign illegal_op       = ill_q;

endmodule

// File: tb/tb_lc3_writeback_sequencer.sv
module tb_lc3_writeback_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       ex_valid;
    logic       ex_ready;
    logic [3:0] ex_opcode;
    logic [2:0] ex_dr;
    logic       mem_req, mem_rw, mem_addr_sel, mem_ack;
    logic [1:0] W_Control;
    logic       enable_writeback;
    logic [2:0] dr;
    logic       retire, mem_error, illegal_op;

    int n_chk  = 0;
    int n_pass = 0;

    lc3_writeback_sequencer #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clock(clock), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_opcode(ex_opcode), .ex_dr(ex_dr),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr_sel(mem_addr_sel),
        .mem_ack(mem_ack),
        .W_Control(W_Control), .enable_writeback(enable_writeback), .dr(dr),
        .retire(retire), .mem_error(mem_error), .illegal_op(illegal_op)
    );

    always #5 clock = ~clock;

    // {ex_ready, mem_req, mem_rw, addr_sel, W_Control, en_wb, dr, retire, err, ill}
    function automatic logic [12:0] pk(input logic rdy, input logic req, input logic rw,
                                       input logic sel, input logic [1:0] wc, input logic en,
                                       input logic [2:0] d, input logic ret, input logic err,
                                       input logic ill);
        return {rdy, req, rw, sel, wc, en, d, ret, err, ill};
    endfunction

    function automatic logic [12:0] obs();
        return {ex_ready, mem_req, mem_rw, mem_addr_sel, W_Control, enable_writeback,
                dr, retire, mem_error, illegal_op};
    endfunction

    task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    // Outputs for the new cycle are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [3:0] op, input logic [2:0] d);
        ex_valid  = 1'b1;
        ex_opcode = op;
        ex_dr     = d;
    endtask

    initial begin
        reset = 1'b1; ex_valid = 1'b0; ex_opcode = '0; ex_dr = '0; mem_ack = 1'b0;
        tick(); tick();
        chk("reset_state", obs(), pk(1,0,0,0,0,0,0,0,0,0));
        reset = 1'b0;
        tick();
        chk("idle_after_reset", obs(), pk(1,0,0,0,0,0,0,0,0,0));

        // ADD dr=3: writeback one cycle after accept, ex_ready low one cycle
        present(4'b0001, 3'd3);
        tick(); ex_valid = 1'b0;
        chk("add_wb", obs(), pk(0,0,0,0,0,1,3,1,0,0));
        tick();
        chk("add_idle", obs(), pk(1,0,0,0,0,0,3,0,0,0));

        // LDI dr=5, ack arrives on the third cycle of each access
        present(4'b1010, 3'd5);
        tick(); ex_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            mem_ack = (c == 3);
            chk($sformatf("ldi_rd_c%0d", c), obs(), pk(0,1,0,0,2,0,5,0,0,0));
            tick();
        end
        for (int c = 1; c <= 3; c++) begin
            mem_ack = (c == 3);
            chk($sformatf("ldi_rdind_c%0d", c), obs(), pk(0,1,0,1,2,0,5,0,0,0));
            tick();
        end
        mem_ack = 1'b0;
        chk("ldi_wb", obs(), pk(0,0,0,0,2,1,5,1,0,0));
        tick();
        chk("ldi_idle", obs(), pk(1,0,0,0,2,0,5,0,0,0));

        // STI dr=2, immediate acks
        present(4'b1011, 3'd2);
        tick(); ex_valid = 1'b0; mem_ack = 1'b1;
        chk("sti_rd", obs(), pk(0,1,0,0,0,0,2,0,0,0));
        tick();
        chk("sti_wr", obs(), pk(0,1,1,1,0,0,2,0,0,0));
        tick(); mem_ack = 1'b0;
        chk("sti_retire", obs(), pk(1,0,0,0,0,0,2,1,0,0));
        tick();
        chk("sti_idle", obs(), pk(1,0,0,0,0,0,2,0,0,0));

        // ST dr=1: direct write, addr_sel stays 0
        present(4'b0011, 3'd1);
        tick(); ex_valid = 1'b0; mem_ack = 1'b1;
        chk("st_wr", obs(), pk(0,1,1,0,0,0,1,0,0,0));
        tick(); mem_ack = 1'b0;
        chk("st_retire", obs(), pk(1,0,0,0,0,0,1,1,0,0));

        // LD dr=4 with no ack: abort after 16 request cycles
        present(4'b0010, 3'd4);
        tick(); ex_valid = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("ld_to_c%0d", c), obs(), pk(0,1,0,0,2,0,4,0,0,0));
            tick();
        end
        chk("ld_to_error", obs(), pk(1,0,0,0,2,0,4,0,1,0));
        tick();
        chk("ld_to_idle", obs(), pk(1,0,0,0,2,0,4,0,0,0));

        // Same LD with ack on the 16th cycle: ack wins
        present(4'b0010, 3'd4);
        tick(); ex_valid = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            mem_ack = (c == 16);
            if (c == 16) chk("ld_lim_c16", obs(), pk(0,1,0,0,2,0,4,0,0,0));
            tick();
        end
        mem_ack = 1'b0;
        chk("ld_lim_wb", obs(), pk(0,0,0,0,2,1,4,1,0,0));
        tick();

        // Reset in the middle of RD_IND
        present(4'b1010, 3'd6);
        tick(); ex_valid = 1'b0; mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        chk("rst_pre_rdind", obs(), pk(0,1,0,1,2,0,6,0,0,0));
        reset = 1'b1; #1;
        chk("rst_async", obs(), pk(1,0,0,0,0,0,0,0,0,0));
        tick(); reset = 1'b0;
        tick();
        chk("rst_no_wb", obs(), pk(1,0,0,0,0,0,0,0,0,0));
        present(4'b0001, 3'd1);
        tick(); ex_valid = 1'b0;
        chk("rst_add_wb", obs(), pk(0,0,0,0,0,1,1,1,0,0));
        tick();

        // LEA then ADD held during WB: second accept only once back in IDLE
        present(4'b1110, 3'd2);
        tick();
        chk("lea_wb", obs(), pk(0,0,0,0,1,1,2,1,0,0));
        present(4'b0001, 3'd4);
        tick();
        chk("lea_idle_accept", obs(), pk(1,0,0,0,1,0,2,0,0,0));
        tick(); ex_valid = 1'b0;
        chk("b2b_add_wb", obs(), pk(0,0,0,0,0,1,4,1,0,0));
        tick();

        // Illegal opcode then BR back-to-back
        present(4'b1111, 3'd7);
        tick();
        chk("illegal_pulse", obs(), pk(1,0,0,0,0,0,7,1,0,1));
        present(4'b0000, 3'd0);
        tick(); ex_valid = 1'b0;
        chk("br_retire", obs(), pk(1,0,0,0,0,0,0,1,0,0));
        mem_ack = 1'b1;   // stray ack in IDLE must be ignored
        tick(); mem_ack = 1'b0;
        chk("br_idle", obs(), pk(1,0,0,0,0,0,0,0,0,0));
        tick();
        chk("stray_ack_idle", obs(), pk(1,0,0,0,0,0,0,0,0,0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
